// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM BIST sequencer: FSM states, address
// widths, word-to-byte address conversion and the test pattern generator.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 24;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned BYTE_ADDR_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_DONE
  } state_e;

  // Controller ports take byte addresses; words are 16-bit, so shift by one.
  function automatic logic [BYTE_ADDR_W-1:0] to_byte_addr(
    input logic [SDRAM_ADDR_W-1:0] word_addr
  );
    return BYTE_ADDR_W'({word_addr, 1'b0});
  endfunction

  // Address-derived pattern; upper address bits fold into the low byte.
  function automatic logic [DATA_W-1:0] pat(
    input logic [SDRAM_ADDR_W-1:0] a,
    input logic [DATA_W-1:0]       seed
  );
    return a[15:0] ^ {8'h00, a[23:16]} ^ seed;
  endfunction

endpackage

// File: rtl/sdram_req_timer.sv
// Per-request ack timeout counter: cleared outside request states, counts
// request cycles, and flags the final permitted cycle without an ack.
module sdram_req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);

  // expired is high during the TIMEOUT_CYCLES-th request cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= (LIMIT == '0);
    end else if (enable) begin
      count   <= count_inc;
      expired <= (count_inc == LIMIT);
    end
  end

endmodule

// File: rtl/sdram_bist_sequencer.sv
// SDRAM built-in self-test: writes a seeded pattern over a word range, reads
// it back, and reports error count, first failing word and ack timeout.
module sdram_bist_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned          ADDR_W         = SDRAM_ADDR_W,
  parameter logic [ADDR_W-1:0]    START_ADDR     = '0,
  parameter logic [ADDR_W-1:0]    LAST_ADDR      = '1,
  parameter int unsigned          TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [DATA_W-1:0]      seed,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [DATA_W-1:0]      err_count,
  output logic [ADDR_W-1:0]      first_err_addr,
  output logic [DATA_W-1:0]      first_err_data,
  output logic                   writeport_wr,
  output logic [BYTE_ADDR_W-1:0] writeport_addr,
  output logic [DATA_W-1:0]      writeport_data,
  input  logic                   writeport_ack,
  output logic                   readport_rd,
  output logic [BYTE_ADDR_W-1:0] readport_addr,
  input  logic [DATA_W-1:0]      readport_data,
  input  logic                   readport_ack
);

  state_e              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DATA_W-1:0]   err_d;
  logic [ADDR_W-1:0]   fea_d;
  logic [DATA_W-1:0]   fed_d;
  logic                timeout_d;
  logic                pass_d;
  logic                in_req;
  logic                expired;
  logic [DATA_W-1:0]   pat_cur;

  assign in_req  = (state == ST_WR_REQ) || (state == ST_RD_REQ);
  assign pat_cur = pat(SDRAM_ADDR_W'(addr), seed_q);

  sdram_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_req),
    .enable  (in_req),
    .expired (expired)
  );

  // Next-state and result-register logic
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    seed_d    = seed_q;
    err_d     = err_count;
    fea_d     = first_err_addr;
    fed_d     = first_err_data;
    timeout_d = timeout;
    pass_d    = pass;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_WR_REQ;
          addr_d    = START_ADDR;
          seed_d    = seed;
          err_d     = '0;
          fea_d     = '0;
          fed_d     = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      ST_WR_REQ: begin
        if (writeport_ack) begin
          state_d = ST_WR_GAP;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_WR_GAP: begin
        if (addr == LAST_ADDR) begin
          addr_d  = START_ADDR;
          state_d = ST_RD_REQ;
        end else begin
          addr_d  = addr + ADDR_W'(1);
          state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (readport_ack) begin
          if (readport_data != pat_cur) begin
            // err_count never returns to zero once set, so zero marks the first miss
            if (err_count == '0) begin
              fea_d = addr;
              fed_d = readport_data;
            end
            if (err_count != '1) err_d = err_count + DATA_W'(1);
          end
          state_d = ST_RD_GAP;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_RD_GAP: begin
        if (addr == LAST_ADDR) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr + ADDR_W'(1);
          state_d = ST_RD_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_DONE) && (state != ST_DONE)) begin
      pass_d = (err_d == '0) && !timeout_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      addr           <= '0;
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      writeport_wr   <= 1'b0;
      writeport_addr <= '0;
      writeport_data <= '0;
      readport_rd    <= 1'b0;
      readport_addr  <= '0;
    end else begin
      state          <= state_d;
      addr           <= addr_d;
      seed_q         <= seed_d;
      err_count      <= err_d;
      first_err_addr <= fea_d;
      first_err_data <= fed_d;
      timeout        <= timeout_d;
      pass           <= pass_d;
      busy           <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done           <= (state_d == ST_DONE);
      writeport_wr   <= (state_d == ST_WR_REQ);
      writeport_addr <= to_byte_addr(SDRAM_ADDR_W'(addr_d));
      writeport_data <= pat(SDRAM_ADDR_W'(addr_d), seed_d);
      readport_rd    <= (state_d == ST_RD_REQ);
      readport_addr  <= to_byte_addr(SDRAM_ADDR_W'(addr_d));
    end
  end

endmodule

// File: doc/sdram_bist_sequencer.md
Name: sdram_bist_sequencer

Overview:
Built-in self-test sequencer that drives the write and read ports of MisterSdram32MBController. It replaces the hand-poked port registers of the SDRAM tester top level. On a start pulse it writes a seeded address-derived pattern over a word range, reads the range back, and compares each word. It reports pass/fail, error count, first failing address/data and ack timeout to the cart debug logic.

Parameters:
ADDR_W, 24, word-address width (16M x 16-bit words = 32 MB)
START_ADDR, 0, first word address tested
LAST_ADDR, 2**24-1, last word address tested inclusive; must be >= START_ADDR
TIMEOUT_CYCLES, 1023, max cycles waiting for any single ack before abort

Ports:
clk  input  1  system clock, all logic rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begin test; ignored while busy
seed  input  16  pattern seed, latched on accepted start
busy  output  1  high from accepted start until done
done  output  1  high after test ends, held until next accepted start
pass  output  1  valid while done: 1 = err_count==0 and no timeout
timeout  output  1  ack not received within TIMEOUT_CYCLES
err_count  output  16  mismatching read words, saturates at 16'hFFFF
first_err_addr  output  ADDR_W  word address of first mismatch
first_err_data  output  16  data read at first mismatch
writeport_wr  output  1  write request to controller
writeport_addr  output  32  byte address {zero-ext, word_addr, 1'b0}
writeport_data  output  16  write data
writeport_ack  input  1  one-cycle write-complete pulse
readport_rd  output  1  read request to controller
readport_addr  output  32  byte address, same format
readport_data  input  16  read data, valid in the cycle readport_ack=1
readport_ack  input  1  one-cycle read-complete pulse

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state IDLE; wr/rd drop immediately, no wait for clock edge.
- Pattern: pat(a) = a[15:0] ^ {8'h00, a[23:16]} ^ seed_q; upper bits truncated, pure XOR.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE/DONE + start: clear err_count, first_err_*, timeout, pass, done; latch seed; addr=START_ADDR; busy=1; go WR_REQ.
- WR_REQ: writeport_wr=1, addr/data stable. Leave on the cycle writeport_ack=1 -> WR_GAP.
- WR_GAP: writeport_wr=0 for exactly one cycle, so each request is a separate transaction. If addr==LAST_ADDR, go RD_REQ with addr=START_ADDR; else addr+1 and go WR_REQ.
- RD_REQ: readport_rd=1. On readport_ack, compare readport_data to pat(addr).
  - On mismatch: err_count+1, saturating.
  - If this is the first mismatch: capture addr and data.
  - Then go RD_GAP.
- RD_GAP: rd=0 for one cycle. If addr==LAST_ADDR, go DONE; else addr+1 and go RD_REQ.
- DONE: busy=0, done=1, pass = (err_count==0 && !timeout). Results held.
- Latency: minimum 2 cycles per word per phase (ack in the first request cycle plus the gap). Total min = 4*(LAST_ADDR-START_ADDR+1)+1 cycles from start to done.
- Timeout:
  - A per-request counter resets on entry to WR_REQ/RD_REQ.
  - If the counter reaches TIMEOUT_CYCLES with no ack: drop wr/rd, set timeout=1, go DONE, pass=0.
  - A stray ack outside the REQ states is ignored.
- start while busy: ignored, no effect on state or seed.
- Address increment never wraps beyond LAST_ADDR; when START_ADDR==LAST_ADDR, test one word.
- Ack and start in the same cycle in a REQ state: ack processed, start ignored.

Decomposition:
- Shared package sdram_pkg holds:
  - the state enum;
  - the SDRAM word-address width (24);
  - the byte-address conversion function;
  - the pattern function pat().
- One sub-module, sdram_req_timer: timeout counter with clear/enable/expired.

Test Plan:
1. START=0, LAST=15, seed=0, model acks 3 cycles after request -> addr 5 written 0x0005; done=1, pass=1, err_count=0, timeout=0.
2. Same setup, model flips bit0 on read of addr 7 -> err_count=1, first_err_addr=7, first_err_data=0x0006, pass=0.
3. Model never acks the first write, TIMEOUT_CYCLES=1023 -> after 1023 cycles writeport_wr=0, timeout=1, done=1, pass=0.
4. start pulsed mid read phase -> ignored, seed unchanged. start in DONE -> counters and first_err_* cleared, full test reruns.
5. reset_n low during WR_REQ -> writeport_wr=0 and busy=0 before the next clk edge; after release, state is IDLE.
6. START=0x010200, LAST=0x010203, seed=0xA5A5 -> write data at 0x010203 is 0xA7A7; writeport_addr=0x00020406; pass=1.
